// File: rtl/mmio_timer_pkg.sv
// mmio_timer_pkg: register map, CTRL bit layout and channel limit
// shared by the timer bank top and its per-channel timer.
package mmio_timer_pkg;

    localparam int MAX_CH = 16;

    localparam logic [1:0] REG_CTRL  = 2'd0;
    localparam logic [1:0] REG_PRESC = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CMP   = 2'd3;

    localparam int CTRL_EN    = 0;
    localparam int CTRL_AR    = 1;
    localparam int CTRL_IE    = 2;
    localparam int CTRL_CAS   = 3;
    localparam int CTRL_MATCH = 8;
    localparam int CTRL_OVF   = 9;

    function automatic logic [31:0] ctrl_word(
        input logic en,
        input logic ar,
        input logic ie,
        input logic cas,
        input logic match,
        input logic ovf
    );
        logic [31:0] w;
        w             = '0;
        w[CTRL_EN]    = en;
        w[CTRL_AR]    = ar;
        w[CTRL_IE]    = ie;
        w[CTRL_CAS]   = cas;
        w[CTRL_MATCH] = match;
        w[CTRL_OVF]   = ovf;
        return w;
    endfunction

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one timer with prescaler, COUNT/CMP, sticky MATCH/OVF
// flags and an optional cascade tick input from the previous channel.
module timer_channel
    import mmio_timer_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 32,
    parameter bit CASC_OK = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        wr_ctrl_i,
    input  logic        wr_presc_i,
    input  logic        wr_count_i,
    input  logic        wr_cmp_i,
    input  logic [31:0] wdata_i,
    input  logic        casc_tick_i,
    output logic [31:0] ctrl_o,
    output logic [31:0] presc_o,
    output logic [31:0] count_o,
    output logic [31:0] cmp_o,
    output logic        ovf_evt_o,
    output logic        irq_o
);

    logic en_q, en_d;
    logic ar_q, ar_d;
    logic ie_q, ie_d;
    logic cas_q, cas_d;
    logic match_q, match_d;
    logic ovf_q, ovf_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [PRESC_W-1:0] psc_q, psc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;

    logic casc_on;
    logic tick;
    logic fire;
    logic hit;
    logic wrap;
    logic [CNT_W-1:0] inc;
    logic unused_in;

    assign casc_on = CASC_OK & cas_q;
    assign tick = en_q & (casc_on ? casc_tick_i : (psc_q == presc_q));
    // A software COUNT write swallows the tick entirely, flags included.
    assign fire = tick & ~wr_count_i;
    assign inc = count_q + CNT_W'(1);
    assign hit = (inc == cmp_q);
    assign wrap = &count_q;
    assign ovf_evt_o = fire & wrap;
    assign unused_in = ^{wdata_i, casc_tick_i};

    // Next-state: prescaler, register writes, tick effects, flag set/clear.
    always_comb begin
        en_d    = en_q;
        ar_d    = ar_q;
        ie_d    = ie_q;
        cas_d   = cas_q;
        match_d = match_q;
        ovf_d   = ovf_q;
        presc_d = presc_q;
        cmp_d   = cmp_q;
        count_d = count_q;
        psc_d   = psc_q + PRESC_W'(1);

        if (!en_q || wr_count_i || wr_presc_i || casc_on ||
            (psc_q == presc_q)) begin
            psc_d = '0;
        end

        if (wr_ctrl_i) begin
            en_d    = wdata_i[CTRL_EN];
            ar_d    = wdata_i[CTRL_AR];
            ie_d    = wdata_i[CTRL_IE];
            cas_d   = CASC_OK ? wdata_i[CTRL_CAS] : 1'b0;
            match_d = match_q & ~wdata_i[CTRL_MATCH];
            ovf_d   = ovf_q & ~wdata_i[CTRL_OVF];
        end
        if (wr_presc_i) begin
            presc_d = wdata_i[PRESC_W-1:0];
        end
        if (wr_cmp_i) begin
            cmp_d = wdata_i[CNT_W-1:0];
        end

        if (wr_count_i) begin
            count_d = wdata_i[CNT_W-1:0];
        end else if (tick) begin
            count_d = (hit && ar_q) ? '0 : inc;
        end

        // Setting wins over a same-cycle write-one-to-clear.
        if (fire && hit) begin
            match_d = 1'b1;
        end
        if (fire && wrap) begin
            ovf_d = 1'b1;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q    <= 1'b0;
            ar_q    <= 1'b0;
            ie_q    <= 1'b0;
            cas_q   <= 1'b0;
            match_q <= 1'b0;
            ovf_q   <= 1'b0;
            presc_q <= '0;
            psc_q   <= '0;
            count_q <= '0;
            cmp_q   <= '0;
        end else begin
            en_q    <= en_d;
            ar_q    <= ar_d;
            ie_q    <= ie_d;
            cas_q   <= cas_d;
            match_q <= match_d;
            ovf_q   <= ovf_d;
            presc_q <= presc_d;
            psc_q   <= psc_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
        end
    end

    assign ctrl_o  = ctrl_word(en_q, ar_q, ie_q, cas_q, match_q, ovf_q);
    assign presc_o = 32'(presc_q);
    assign count_o = 32'(count_q);
    assign cmp_o   = 32'(cmp_q);
    // Built only from flops, so irq follows the flags with no added delay.
    assign irq_o   = (match_q | ovf_q) & ie_q;

endmodule

// File: rtl/mmio_timer_bank.sv
// mmio_timer_bank: MMIO decode, registered read mux and cascade wiring
// for NUM_CH timer channels. Optional macro: TIMER_CASCADE_EN.
module mmio_timer_bank
    import mmio_timer_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 32,
    parameter int PRESC_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        addr,
    input  logic              re,
    input  logic              we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] irq
);

`ifdef TIMER_CASCADE_EN
    localparam bit CASC_EN = 1'b1;
`else
    localparam bit CASC_EN = 1'b0;
`endif

    localparam int N = (NUM_CH < MAX_CH) ? NUM_CH : MAX_CH;

    logic [3:0] ch_sel;
    logic [1:0] reg_sel;
    logic [N-1:0] ovf_evt;
    logic [N-1:0] irq_ch;
    logic [31:0] rd_ctrl [N];
    logic [31:0] rd_presc [N];
    logic [31:0] rd_count [N];
    logic [31:0] rd_cmp [N];
    logic [31:0] rdata_q, rdata_d;
    logic unused_addr;

    assign ch_sel = addr[7:4];
    assign reg_sel = addr[3:2];
    assign unused_addr = ^{addr[1:0], ovf_evt[N-1]};

    for (genvar i = 0; i < N; i++) begin : g_ch
        logic hit;
        logic casc_in;

        assign hit = we && (ch_sel == 4'(i));

        if (i == 0) begin : g_first
            assign casc_in = 1'b0;
        end else begin : g_rest
            assign casc_in = ovf_evt[i-1];
        end

        timer_channel #(
            .CNT_W   (CNT_W),
            .PRESC_W (PRESC_W),
            .CASC_OK (CASC_EN && (i >= 1))
        ) u_ch (
            .clk_i       (clock),
            .rst_i       (reset),
            .wr_ctrl_i   (hit && (reg_sel == REG_CTRL)),
            .wr_presc_i  (hit && (reg_sel == REG_PRESC)),
            .wr_count_i  (hit && (reg_sel == REG_COUNT)),
            .wr_cmp_i    (hit && (reg_sel == REG_CMP)),
            .wdata_i     (wdata),
            .casc_tick_i (casc_in),
            .ctrl_o      (rd_ctrl[i]),
            .presc_o     (rd_presc[i]),
            .count_o     (rd_count[i]),
            .cmp_o       (rd_cmp[i]),
            .ovf_evt_o   (ovf_evt[i]),
            .irq_o       (irq_ch[i])
        );
    end

    for (genvar j = N; j < NUM_CH; j++) begin : g_pad
        assign irq[j] = 1'b0;
    end
    assign irq[N-1:0] = irq_ch;

    // Read mux; absent channels fall through to zero.
    always_comb begin
        rdata_d = '0;
        for (int i = 0; i < N; i++) begin
            if (ch_sel == 4'(i)) begin
                unique case (reg_sel)
                    REG_CTRL:  rdata_d = rd_ctrl[i];
                    REG_PRESC: rdata_d = rd_presc[i];
                    REG_COUNT: rdata_d = rd_count[i];
                    REG_CMP:   rdata_d = rd_cmp[i];
                endcase
            end
        end
    end

    // Read data register, captured on re and held until the next read.
    always_ff @(posedge clock) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule
